// File: rtl/popcount_window_stats.sv
// Purpose: accumulates WINDOW popcount samples and reports their sum, min, max and range error.
// Latency: the result is visible 1 cycle after the final sample of a window is accepted.
// Backpressure: a one-entry result buffer; in_ready drops only for a final sample that would
//   overwrite an unconsumed result, or while clear is high.
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   clear           - discards the partial window in progress (results untouched)
//   in_valid/ready  - sample handshake, in_count is a 5-bit ones-count (legal 0..16)
//   out_valid/ready - result handshake for out_sum/out_min/out_max/out_err
module popcount_window_stats #(
  parameter int WINDOW = 8,
  parameter int SUM_W  = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [4:0]       out_min,
  output logic [4:0]       out_max,
  output logic             out_err
);

  localparam int IDX_W = $clog2(WINDOW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] acc_sum;
  logic [4:0]       acc_min;
  logic [4:0]       acc_max;
  logic             acc_err;

  logic             is_last;
  logic             accept;
  logic [SUM_W-1:0] nxt_sum;
  logic [4:0]       nxt_min;
  logic [4:0]       nxt_max;
  logic             nxt_err;

  assign is_last = (idx == LAST_IDX);

  // A final sample may enter only when the result buffer is free or being drained
  // in the same cycle, so a pending result is never overwritten.
  assign in_ready = !clear && (!is_last || !out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Accumulator values including the current sample; used for both the
  // mid-window update and the final result load.
  assign nxt_sum = acc_sum + SUM_W'(in_count);
  assign nxt_min = (in_count < acc_min) ? in_count : acc_min;
  assign nxt_max = (in_count > acc_max) ? in_count : acc_max;
  assign nxt_err = acc_err || (in_count > 5'd16);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      acc_sum   <= '0;
      acc_min   <= 5'd31;
      acc_max   <= 5'd0;
      acc_err   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_min   <= 5'd0;
      out_max   <= 5'd0;
      out_err   <= 1'b0;
    end else begin
      // Drain first; a same-cycle result load below overrides this.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (clear) begin
        idx     <= '0;
        acc_sum <= '0;
        acc_min <= 5'd31;
        acc_max <= 5'd0;
        acc_err <= 1'b0;
      end else if (accept) begin
        if (is_last) begin
          out_sum   <= nxt_sum;
          out_min   <= nxt_min;
          out_max   <= nxt_max;
          out_err   <= nxt_err;
          out_valid <= 1'b1;
          idx       <= '0;
          acc_sum   <= '0;
          acc_min   <= 5'd31;
          acc_max   <= 5'd0;
          acc_err   <= 1'b0;
        end else begin
          idx     <= idx + 1'b1;
          acc_sum <= nxt_sum;
          acc_min <= nxt_min;
          acc_max <= nxt_max;
          acc_err <= nxt_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_window_stats.sv
// Purpose: directed self-checking bench for popcount_window_stats with WINDOW=4.
// Latency: results are checked 1 cycle after the final sample of each window.
// Backpressure: exercises result stall, same-cycle drain/load, clear and mid-window reset.
module tb_popcount_window_stats;

  localparam int WINDOW = 4;
  localparam int SUM_W  = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_count;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [4:0]       out_min;
  logic [4:0]       out_max;
  logic             out_err;

  int errors = 0;
  int checks = 0;

  popcount_window_stats #(.WINDOW(WINDOW), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and step off it before inputs change or outputs are read.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {out_valid, out_sum, out_min, out_max, out_err}
  function automatic logic [24:0] res(input logic v, input int s, input int mn, input int mx,
                                      input logic e);
    res = {v, SUM_W'(s), 5'(mn), 5'(mx), e};
  endfunction

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_count = 5'd0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({out_valid, out_sum, out_min, out_max, out_err} !== res(0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h",
               {out_valid, out_sum, out_min, out_max, out_err}, res(0, 0, 0, 0, 0));
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int smp[4] = '{3, 0, 16, 7};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_count = 5'(smp[i]);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      tick();
      in_valid = 1'b0;
    end
    checks++;
    if ({out_valid, out_sum, out_min, out_max, out_err} !== res(1, 26, 0, 16, 0)) begin
      errors++;
      $display("FAIL basic_result: got %h expected %h",
               {out_valid, out_sum, out_min, out_max, out_err}, res(1, 26, 0, 16, 0));
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_count = 5'd16;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      tick();
      if (i == 3 || i == 7) begin
        checks++;
        if ({out_valid, out_sum, out_min, out_max, out_err} !== res(1, 64, 16, 16, 0)) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got %h expected %h", i,
                   {out_valid, out_sum, out_min, out_max, out_err}, res(1, 64, 16, 16, 0));
        end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    // Samples 1..7 all accept: 4 complete the first window, 3 more bring idx to 3.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_count = 5'd1;
      tick();
    end
    for (int h = 0; h < 3; h++) begin
      checks++;
      if ({in_ready, out_valid, out_sum} !== {1'b0, 1'b1, 13'd4}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got in_ready=%b out_valid=%b sum=%0d expected 0 1 4",
                 h, in_ready, out_valid, out_sum);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sum, out_min, out_max, out_err, in_ready} !== {res(1, 4, 1, 1, 0), 1'b1})
    begin
      errors++;
      $display("FAIL stall_second_result: got %h expected %h",
               {out_valid, out_sum, out_min, out_max, out_err, in_ready},
               {res(1, 4, 1, 1, 0), 1'b1});
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_err();
    int smp[8] = '{5, 17, 2, 9, 1, 1, 1, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_count = 5'(smp[i]);
      tick();
      if (i == 3) begin
        checks++;
        if ({out_valid, out_sum, out_min, out_max, out_err} !== res(1, 33, 2, 17, 1)) begin
          errors++;
          $display("FAIL err_window: got %h expected %h",
                   {out_valid, out_sum, out_min, out_max, out_err}, res(1, 33, 2, 17, 1));
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_sum, out_min, out_max, out_err} !== res(1, 4, 1, 1, 0)) begin
      errors++;
      $display("FAIL err_cleared_next: got %h expected %h",
               {out_valid, out_sum, out_min, out_max, out_err}, res(1, 4, 1, 1, 0));
    end
    tick();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_count = 5'd9;
      tick();
    end
    clear = 1'b1; in_count = 5'd9;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_ready: got %b expected 0", in_ready);
    end
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_count = 5'd4;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_sum, out_min, out_max, out_err} !== res(1, 16, 4, 4, 0)) begin
      errors++;
      $display("FAIL clear_result: got %h expected %h",
               {out_valid, out_sum, out_min, out_max, out_err}, res(1, 16, 4, 4, 0));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int smp[4] = '{1, 2, 3, 4};
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_count = 5'd7;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_sum} !== {1'b1, 13'd28}) begin
      errors++;
      $display("FAIL rstmid_pending: got valid=%b sum=%0d expected 1 28", out_valid, out_sum);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_sum, out_min, out_max, out_err} !== res(0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL rstmid_outputs: got %h expected %h",
               {out_valid, out_sum, out_min, out_max, out_err}, res(0, 0, 0, 0, 0));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_count = 5'(smp[i]);
      tick();
      if (i == 1) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_no_early_result: out_valid got %b expected 0", out_valid);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_sum, out_min, out_max, out_err} !== res(1, 10, 1, 4, 0)) begin
      errors++;
      $display("FAIL rstmid_result: got %h expected %h",
               {out_valid, out_sum, out_min, out_max, out_err}, res(1, 10, 1, 4, 0));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_err();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
